// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single write port of the register file between two writeback
// requesters: A (ALU) and B (load/memory). Writes to r0 are accepted
// immediately and dropped without using the port. Non-zero writes are
// arbitrated (round-robin, or A-first when FIXED_PRIO=1) and registered onto
// RegWrite/writereg/writedata one cycle after acceptance.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_reg/a_data  requester A handshake and write payload
//   b_valid/b_ready/b_reg/b_data  requester B handshake and write payload
//   RegWrite/writereg/writedata   registered write to the register file
//   wb_busy                    one-hot of writereg while RegWrite is high
//   rr_ptr                     favoured requester on contention (0=A, 1=B)

module regfile_wb_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int DW         = 16,
   parameter int AW         = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [AW-1:0]        a_reg,
   input  logic [DW-1:0]        a_data,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [AW-1:0]        b_reg,
   input  logic [DW-1:0]        b_data,
   output logic                 RegWrite,
   output logic [AW-1:0]        writereg,
   output logic [DW-1:0]        writedata,
   output logic [(1<<AW)-1:0]   wb_busy,
   output logic                 rr_ptr
);

   logic          a_req, a_zero, b_req, b_zero;
   logic          grant_a, grant_b;
   logic          rr_ptr_q, rr_ptr_d;
   logic          regwrite_q, regwrite_d;
   logic [AW-1:0] writereg_q, writereg_d;
   logic [DW-1:0] writedata_q, writedata_d;

   always_comb begin
      a_req  = a_valid && (a_reg != '0);
      a_zero = a_valid && (a_reg == '0);
      b_req  = b_valid && (b_reg != '0);
      b_zero = b_valid && (b_reg == '0);
      // A wins when alone, when priority is fixed, or when it is favoured.
      grant_a = a_req && (!b_req || (FIXED_PRIO != 0) || !rr_ptr_q);
      grant_b = b_req && !grant_a;
   end

   // r0 writes are swallowed the same cycle; readies are held low in reset.
   assign a_ready = rst_n && (a_zero || grant_a);
   assign b_ready = rst_n && (b_zero || grant_b);

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      regwrite_d  = 1'b0;
      writereg_d  = writereg_q;
      writedata_d = writedata_q;
      if (grant_a) begin
         rr_ptr_d    = 1'b1;
         regwrite_d  = 1'b1;
         writereg_d  = a_reg;
         writedata_d = a_data;
      end else if (grant_b) begin
         rr_ptr_d    = 1'b0;
         regwrite_d  = 1'b1;
         writereg_d  = b_reg;
         writedata_d = b_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= 1'b0;
         regwrite_q  <= 1'b0;
         writereg_q  <= '0;
         writedata_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         regwrite_q  <= regwrite_d;
         writereg_q  <= writereg_d;
         writedata_q <= writedata_d;
      end
   end

   always_comb begin
      wb_busy = '0;
      if (regwrite_q) wb_busy[writereg_q] = 1'b1;
      // A granted write never targets r0; keep bit 0 clear regardless.
      wb_busy[0] = 1'b0;
   end

   assign RegWrite  = regwrite_q;
   assign writereg  = writereg_q;
   assign writedata = writedata_q;
   assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   typedef struct packed {
      logic [2:0]  r;
      logic [15:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [2:0]  a_reg = '0, b_reg = '0;
   logic [15:0] a_data = '0, b_data = '0;

   logic        rr_a_ready, rr_b_ready, rr_rw, rr_ptr_o;
   logic [2:0]  rr_wreg;
   logic [15:0] rr_wdata;
   logic [7:0]  rr_busy;
   logic        fx_a_ready, fx_b_ready, fx_rw, fx_ptr_o;
   logic [2:0]  fx_wreg;
   logic [15:0] fx_wdata;
   logic [7:0]  fx_busy;

   regfile_wb_arbiter #(.FIXED_PRIO(0), .DW(16), .AW(3)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(rr_a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(rr_b_ready), .b_reg(b_reg), .b_data(b_data),
      .RegWrite(rr_rw), .writereg(rr_wreg), .writedata(rr_wdata),
      .wb_busy(rr_busy), .rr_ptr(rr_ptr_o)
   );

   regfile_wb_arbiter #(.FIXED_PRIO(1), .DW(16), .AW(3)) u_fx (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(fx_a_ready), .a_reg(a_reg), .a_data(a_data),
      .b_valid(b_valid), .b_ready(fx_b_ready), .b_reg(b_reg), .b_data(b_data),
      .RegWrite(fx_rw), .writereg(fx_wreg), .writedata(fx_wdata),
      .wb_busy(fx_busy), .rr_ptr(fx_ptr_o)
   );

   always #5 clk = ~clk;

   // Which instance is under observation: 0 = round-robin, 1 = fixed priority.
   bit fx = 1'b0;

   logic        o_ar, o_br, o_rw, o_ptr;
   logic [2:0]  o_wreg;
   logic [15:0] o_wdata;
   logic [7:0]  o_busy;
   assign o_ar    = fx ? fx_a_ready : rr_a_ready;
   assign o_br    = fx ? fx_b_ready : rr_b_ready;
   assign o_rw    = fx ? fx_rw      : rr_rw;
   assign o_ptr   = fx ? fx_ptr_o   : rr_ptr_o;
   assign o_wreg  = fx ? fx_wreg    : rr_wreg;
   assign o_wdata = fx ? fx_wdata   : rr_wdata;
   assign o_busy  = fx ? fx_busy    : rr_busy;

   int total = 0;
   int bad = 0;

   // Reference model: pending request per requester, favoured requester,
   // expected commits in order, and the register file contents they imply.
   wr_t         exp_q[$];
   bit          fav;
   bit          pa_v, pb_v;
   logic [2:0]  pa_r, pb_r;
   logic [15:0] pa_d, pb_d;
   logic [15:0] model_rf[8];
   logic [15:0] dut_rf[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic req_a(input logic [2:0] r, input logic [15:0] d);
      pa_v = 1'b1; pa_r = r; pa_d = d;
   endtask

   task automatic req_b(input logic [2:0] r, input logic [15:0] d);
      pb_v = 1'b1; pb_r = r; pb_d = d;
   endtask

   // One cycle: present pending requests, check the handshake, and record
   // the commit the port owes for the coming edge.
   task automatic step();
      int  win;
      bit  ea, eb;
      @(negedge clk);
      a_valid = pa_v; a_reg = pa_r; a_data = pa_d;
      b_valid = pb_v; b_reg = pb_r; b_data = pb_d;
      win = 0;
      if (pa_v && pa_r != 0 && pb_v && pb_r != 0) win = (fx || fav == 1'b0) ? 1 : 2;
      else if (pa_v && pa_r != 0) win = 1;
      else if (pb_v && pb_r != 0) win = 2;
      ea = (pa_v && pa_r == 0) || win == 1;
      eb = (pb_v && pb_r == 0) || win == 2;
      #1;
      chk("a_ready", {31'd0, o_ar}, {31'd0, ea});
      chk("b_ready", {31'd0, o_br}, {31'd0, eb});
      chk("rr_ptr", {31'd0, o_ptr}, {31'd0, fav});
      if (win == 1) begin exp_q.push_back('{r: pa_r, d: pa_d}); fav = 1'b1; end
      if (win == 2) begin exp_q.push_back('{r: pb_r, d: pb_d}); fav = 1'b0; end
      if (ea) pa_v = 1'b0;
      if (eb) pb_v = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      fav = 1'b0;
      pa_v = 1'b0; pb_v = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_model();
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_req();
      if (!pa_v && ($urandom % 3) != 0) req_a(3'($urandom_range(0, 7)), 16'($urandom));
      if (!pb_v && ($urandom % 3) != 0) req_b(3'($urandom_range(0, 7)), 16'($urandom));
   endtask

   // Monitor: every cycle after an acceptance edge the port must show exactly
   // the oldest owed commit; with nothing owed it must be idle.
   always @(negedge clk) begin : mon
      wr_t        e;
      logic [7:0] eb;
      if (rst_n) begin
         chk("RegWrite", {31'd0, o_rw}, {31'd0, exp_q.size() != 0});
         if (o_rw && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            model_rf[e.r] = e.d;
            eb = 8'd1 << e.r;
            chk("writereg", {29'd0, o_wreg}, {29'd0, e.r});
            chk("writedata", {16'd0, o_wdata}, {16'd0, e.d});
            chk("wb_busy", {24'd0, o_busy}, {24'd0, eb});
         end else if (!o_rw) begin
            chk("wb_busy_idle", {24'd0, o_busy}, 32'd0);
         end
         if (o_rw && o_wreg != 3'd0) dut_rf[o_wreg] = o_wdata;
      end
   end

   // A requester must not withdraw valid before it is accepted.
   bit hold_a = 1'b0, hold_b = 1'b0;
   always @(posedge clk) begin
      if (!rst_n) begin
         hold_a = 1'b0; hold_b = 1'b0;
      end else begin
         if (hold_a && !a_valid) begin bad++; $display("FAIL a_valid_withdrawn @%0t", $time); end
         if (hold_b && !b_valid) begin bad++; $display("FAIL b_valid_withdrawn @%0t", $time); end
         hold_a = a_valid && !o_ar;
         hold_b = b_valid && !o_br;
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end
      clear_model();
      #1;
      chk("reset_RegWrite", {31'd0, o_rw}, 32'd0);
      chk("reset_wb_busy", {24'd0, o_busy}, 32'd0);
      chk("reset_writedata", {16'd0, o_wdata}, 32'd0);
      chk("reset_rr_ptr", {31'd0, o_ptr}, 32'd0);
      do_reset();

      // Single requester: r3 = 0x1234.
      req_a(3'd3, 16'h1234);
      step();
      step();
      chk("single_writereg", {29'd0, o_wreg}, 32'd3);
      chk("single_writedata", {16'd0, o_wdata}, 32'h1234);
      chk("single_wb_busy", {24'd0, o_busy}, 32'h08);
      chk("single_rr_ptr", {31'd0, o_ptr}, 32'd1);

      // Reset asserted mid-cycle while a write is registered.
      req_a(3'd2, 16'h5555);
      step();
      @(posedge clk);
      #2;
      chk("pre_reset_RegWrite", {31'd0, o_rw}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_RegWrite", {31'd0, o_rw}, 32'd0);
      chk("async_wb_busy", {24'd0, o_busy}, 32'd0);
      chk("async_rr_ptr", {31'd0, o_ptr}, 32'd0);
      chk("async_a_ready", {31'd0, o_ar}, 32'd0);
      clear_model();
      @(negedge clk);
      #2 rst_n = 1'b1;
      step();
      step();
      chk("post_reset_idle", {31'd0, o_rw}, 32'd0);

      // Round-robin contention from reset.
      do_reset();
      req_a(3'd1, 16'h0011);
      req_b(3'd2, 16'h0022);
      step();
      step();
      step();
      chk("rr_second_writereg", {29'd0, o_wreg}, 32'd2);
      chk("rr_second_rr_ptr", {31'd0, o_ptr}, 32'd0);

      // Same register with B favoured: B commits first, A last.
      req_a(3'd7, 16'h0707);
      step();
      req_a(3'd5, 16'hAAAA);
      req_b(3'd5, 16'hBBBB);
      step();
      step();
      step();
      step();
      chk("same_reg_final", {16'd0, dut_rf[5]}, 32'hAAAA);

      // r0 write alongside a real write.
      req_a(3'd0, 16'hFFFF);
      req_b(3'd4, 16'h0044);
      step();
      step();
      chk("r0_writereg", {29'd0, o_wreg}, 32'd4);
      chk("r0_rr_ptr", {31'd0, o_ptr}, 32'd0);
      step();

      for (int i = 0; i < 300; i++) begin
         rand_req();
         step();
      end
      while (pa_v || pb_v) step();
      step();
      step();

      // Fixed priority: A streams, B starves until A stops.
      fx = 1'b1;
      do_reset();
      req_b(3'd6, 16'h0666);
      for (int i = 0; i < 10; i++) begin
         req_a(3'($urandom_range(1, 7)), 16'($urandom));
         step();
         chk("fx_b_starved", {31'd0, o_br}, 32'd0);
      end
      step();
      chk("fx_b_granted", {31'd0, o_br}, 32'd1);
      step();
      step();

      for (int i = 0; i < 300; i++) begin
         rand_req();
         step();
      end
      for (int i = 0; i < 40 && (pa_v || pb_v); i++) step();
      pa_v = 1'b0; pb_v = 1'b0;
      step();
      step();

      chk("queue_drained", exp_q.size(), 32'd0);
      for (int i = 0; i < 8; i++) chk("regfile", {16'd0, dut_rf[i]}, {16'd0, model_rf[i]});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
